tpu_instr_dispatch: RTL and testbench

TPU_INSTR_DISPATCH -- requirements
Module: tpu_instr_dispatch

---
 rtl/tpu_package.sv | 18 +
 rtl/tpu_sync_fifo.sv | 69 ++++++
 rtl/tpu_instr_dispatch.sv | 122 ++++++++++++
 tb/tb_tpu_instr_dispatch.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_package.sv
// Shared TPU definitions: instruction width, dispatch FSM states and the
// default fence-bit position used by the instruction dispatcher.
package tpu_package;

  localparam int INSTR_SIZE = 32;

  typedef enum logic [1:0] {
    DISP_RUN        = 2'd0,
    DISP_FENCE_WAIT = 2'd1,
    DISP_DRAIN      = 2'd2
  } disp_state_e;

  // The fence marker defaults to the top bit of whatever width is in use.
  function automatic int fence_bit_default(input int instr_w);
    return instr_w - 1;
  endfunction

endpackage

// File: rtl/tpu_sync_fifo.sv
// First-word-fall-through circular buffer with extra-MSB pointers; clear_i
// drops all entries and any push in the same cycle.
module tpu_sync_fifo
  import tpu_package::*;
#(
  parameter int WIDTH = INSTR_SIZE,
  parameter int DEPTH = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     clear_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             push_ok;
  logic             pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

  assign push_ok = push_i && !full_o && !clear_i;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end
    // Clearing catches the read pointer up to the write pointer.
    if (clear_i) begin
      rd_ptr_d = wr_ptr_q;
    end else if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/tpu_instr_dispatch.sv
// Instruction dispatcher: queues instructions, limits outstanding issues,
// serialises fences and drains outstanding work after a flush.
module tpu_instr_dispatch
  import tpu_package::*;
#(
  parameter int INSTR_W   = INSTR_SIZE,
  parameter int DEPTH     = 8,
  parameter int MAX_OUTST = 2,
  parameter int FENCE_BIT = fence_bit_default(INSTR_W)
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     write_i,
  input  logic [INSTR_W-1:0]       instr_i,
  input  logic                     flush_i,
  input  logic                     issue_ready_i,
  input  logic                     done_i,
  output logic                     issue_valid_o,
  output logic [INSTR_W-1:0]       instr_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [2:0]               outst_o,
  output logic                     idle_o,
  output logic [1:0]               err_o
);

  localparam logic [2:0] MAX_OUTST_L = 3'(MAX_OUTST);

  disp_state_e state_q, state_d;
  logic [2:0]  outst_q, outst_d;
  logic [1:0]  err_q, err_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        head_fence;
  logic        issue_fire;
  logic        done_ok;
  logic        done_underflow;
  logic        overflow;

  tpu_sync_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (write_i),
    .pop_i   (issue_fire),
    .clear_i (flush_i),
    .wdata_i (instr_i),
    .rdata_o (instr_o),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .count_o (count_o)
  );

  assign head_fence     = !fifo_empty && instr_o[FENCE_BIT];
  assign issue_fire     = issue_valid_o && issue_ready_i;
  assign done_ok        = done_i && (outst_q != 3'd0);
  assign done_underflow = done_i && (outst_q == 3'd0);
  assign overflow       = write_i && fifo_full;

  assign full_o  = fifo_full;
  assign outst_o = outst_q;
  assign err_o   = err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= DISP_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      DISP_RUN: begin
        if (head_fence && (outst_q != 3'd0)) begin
          state_d = DISP_FENCE_WAIT;
        end
      end
      DISP_FENCE_WAIT, DISP_DRAIN: begin
        if (outst_q == 3'd0) begin
          state_d = DISP_RUN;
        end
      end
      default: state_d = DISP_RUN;
    endcase
    // A flush overrides every other transition.
    if (flush_i) begin
      state_d = DISP_DRAIN;
    end
  end

  always_comb begin
    issue_valid_o = (state_q == DISP_RUN) && !fifo_empty &&
                    (outst_q < MAX_OUTST_L) &&
                    !(head_fence && (outst_q != 3'd0));
    idle_o        = fifo_empty && (outst_q == 3'd0) && (state_q == DISP_RUN);
  end

  always_comb begin
    outst_d = outst_q;
    unique case ({issue_fire, done_ok})
      2'b10:   outst_d = outst_q + 3'd1;
      2'b01:   outst_d = outst_q - 3'd1;
      default: outst_d = outst_q;
    endcase
    err_d = err_q | {done_underflow, overflow};
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      outst_q <= 3'd0;
      err_q   <= 2'b00;
    end else begin
      outst_q <= outst_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tpu_instr_dispatch.sv
// Scoreboard bench for tpu_instr_dispatch: expected instructions are queued
// on push and compared against every issue handshake.
module tb_tpu_instr_dispatch;
  import tpu_package::*;

  localparam int INSTR_W   = 32;
  localparam int DEPTH     = 8;
  localparam int MAX_OUTST = 2;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic               clk_i         = 1'b0;
  logic               rst_i         = 1'b0;
  logic               write_i       = 1'b0;
  logic               flush_i       = 1'b0;
  logic               issue_ready_i = 1'b0;
  logic               done_i        = 1'b0;
  logic [INSTR_W-1:0] instr_i       = '0;
  logic               issue_valid_o;
  logic [INSTR_W-1:0] instr_o;
  logic               full_o;
  logic [CW-1:0]      count_o;
  logic [2:0]         outst_o;
  logic               idle_o;
  logic [1:0]         err_o;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  logic [INSTR_W-1:0] exp_q [$];
  int                 hs_cyc [$];

  tpu_instr_dispatch #(
    .INSTR_W   (INSTR_W),
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .FENCE_BIT (INSTR_W - 1)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .write_i       (write_i),
    .instr_i       (instr_i),
    .flush_i       (flush_i),
    .issue_ready_i (issue_ready_i),
    .done_i        (done_i),
    .issue_valid_o (issue_valid_o),
    .instr_o       (instr_o),
    .full_o        (full_o),
    .count_o       (count_o),
    .outst_o       (outst_o),
    .idle_o        (idle_o),
    .err_o         (err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // A handshake seen on the falling edge completes at the next rising edge.
  always @(negedge clk_i) begin
    if (rst_i && issue_valid_o && issue_ready_i) begin
      hs_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check_eq("issue_unexpected", 64'(issue_valid_o), 64'd0);
      end else begin
        check_eq("issue_instr", 64'(instr_o), 64'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push(input logic [INSTR_W-1:0] data, input bit accept);
    write_i = 1'b1;
    instr_i = data;
    if (accept) exp_q.push_back(data);
    tick();
    write_i = 1'b0;
  endtask

  task automatic check_reset_outputs(input string phase);
    check_eq({phase, "_valid"}, 64'(issue_valid_o), 64'd0);
    check_eq({phase, "_full"},  64'(full_o),        64'd0);
    check_eq({phase, "_count"}, 64'(count_o),       64'd0);
    check_eq({phase, "_outst"}, 64'(outst_o),       64'd0);
    check_eq({phase, "_idle"},  64'(idle_o),        64'd1);
    check_eq({phase, "_err"},   64'(err_o),         64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_i = 1'b1;
    tick();

    // Overflow: 9 pushes into an 8-deep queue with no issues
    for (int i = 0; i < 9; i++) begin
      push(32'h100 + 32'(i), i < 8);
      if (i == 7) begin
        check_eq("ovf_full8",  64'(full_o),  64'd1);
        check_eq("ovf_count8", 64'(count_o), 64'd8);
        check_eq("ovf_err8",   64'(err_o),   64'd0);
      end
    end
    check_eq("ovf_err9",   64'(err_o),   64'd1);
    check_eq("ovf_count9", 64'(count_o), 64'd8);
    issue_ready_i = 1'b1;
    tick();
    done_i = 1'b1;
    repeat (8) tick();
    done_i = 1'b0;
    check_eq("ovf_drain_outst", 64'(outst_o), 64'd0);
    check_eq("ovf_drain_count", 64'(count_o), 64'd0);
    check_eq("ovf_drain_idle",  64'(idle_o),  64'd1);
    check_eq("ovf_err_sticky",  64'(err_o),   64'd1);
    check_eq("ovf_sb_empty",    64'(exp_q.size()), 64'd0);

    rst_i = 1'b0;
    tick();
    check_eq("rst_clears_err", 64'(err_o), 64'd0);
    rst_i = 1'b1;
    tick();

    // Outstanding limit: A and B issue back to back, C waits for a done
    hs_cyc.delete();
    push(32'h0000_00A0, 1'b1);
    push(32'h0000_00B0, 1'b1);
    push(32'h0000_00C0, 1'b1);
    check_eq("lim_outst2",  64'(outst_o),       64'd2);
    check_eq("lim_c_held",  64'(issue_valid_o), 64'd0);
    check_eq("lim_count1",  64'(count_o),       64'd1);
    check_eq("lim_hs_num",  64'(hs_cyc.size()), 64'd2);
    if (hs_cyc.size() == 2) check_eq("lim_b2b", 64'(hs_cyc[1] - hs_cyc[0]), 64'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("lim_c_valid", 64'(issue_valid_o), 64'd1);
    check_eq("lim_outst1",  64'(outst_o),       64'd1);
    tick();
    check_eq("lim_outst2b", 64'(outst_o),       64'd2);
    done_i = 1'b1;
    repeat (2) tick();
    done_i = 1'b0;
    check_eq("lim_idle",    64'(idle_o),        64'd1);

    // Fence: A issues, fence waits, issues two cycles after the done
    push(32'h0000_0AAA, 1'b1);
    push(32'h8000_00F0, 1'b1);
    tick();
    check_eq("fen_state_fw", 64'(dut.state_q),   64'(DISP_FENCE_WAIT));
    check_eq("fen_held",     64'(issue_valid_o), 64'd0);
    check_eq("fen_outst1",   64'(outst_o),       64'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("fen_wait_1",   64'(issue_valid_o), 64'd0);
    check_eq("fen_outst0",   64'(outst_o),       64'd0);
    tick();
    check_eq("fen_valid_2",  64'(issue_valid_o), 64'd1);
    check_eq("fen_state_run", 64'(dut.state_q),  64'(DISP_RUN));
    tick();
    check_eq("fen_issued",   64'(outst_o),       64'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("fen_idle",     64'(idle_o),        64'd1);

    // Flush with 5 queued and 1 outstanding, push in the flush cycle dropped
    push(32'h0000_0111, 1'b1);
    tick();
    issue_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) push(32'h200 + 32'(i), 1'b1);
    check_eq("fl_count5", 64'(count_o), 64'd5);
    check_eq("fl_outst1", 64'(outst_o), 64'd1);
    check_eq("fl_sb5",    64'(exp_q.size()), 64'd5);
    flush_i = 1'b1;
    write_i = 1'b1;
    instr_i = 32'hDEAD_BEEF;
    tick();
    flush_i = 1'b0;
    write_i = 1'b0;
    exp_q.delete();
    check_eq("fl_count0", 64'(count_o),       64'd0);
    check_eq("fl_drain",  64'(dut.state_q),   64'(DISP_DRAIN));
    check_eq("fl_valid0", 64'(issue_valid_o), 64'd0);
    check_eq("fl_outst",  64'(outst_o),       64'd1);
    issue_ready_i = 1'b1;
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("fl_outst0", 64'(outst_o), 64'd0);
    check_eq("fl_idle0",  64'(idle_o),  64'd0);
    tick();
    check_eq("fl_idle1",  64'(idle_o),  64'd1);

    // Done underflow, then reset in the middle of traffic
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("uf_err",   64'(err_o),   64'd2);
    check_eq("uf_outst", 64'(outst_o), 64'd0);
    issue_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) push(32'h300 + 32'(i), 1'b1);
    issue_ready_i = 1'b1;
    tick();
    check_eq("mid_outst1", 64'(outst_o), 64'd1);
    #3;
    rst_i = 1'b0;
    #1;
    exp_q.delete();
    check_reset_outputs("async_rst");
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    push(32'h0000_0777, 1'b1);
    tick();
    check_eq("post_rst_outst", 64'(outst_o), 64'd1);
    done_i = 1'b1;
    tick();
    done_i = 1'b0;
    check_eq("post_rst_idle", 64'(idle_o), 64'd1);
    check_eq("post_rst_err",  64'(err_o),  64'd0);
    check_eq("final_sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
